tinker_fetch: RTL
=================

# tinker_fetch

Instruction fetch stage for the Tinker core. Holds the 64-bit program counter, issues 32-bit instruction reads to memory over a valid/ready request channel, buffers in-order responses in a small queue, and presents `{pc, instruction}` to the decode/execute stage (`tinker_core`) over a valid/ready handshake. A redirect input (branch/jump/return) flushes the queue and discards stale in-flight responses.

## Interface
- `RESET_PC`, 64'h2000: first fetch address after reset.
- `QDEPTH`, 4: instruction queue depth and maximum in-flight reads. Power of 2, ≥2.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: one-cycle pulse; next PC is `redirect_pc`.
- `redirect_pc` in 64: redirect target, byte address.
- `mem_req_valid` out 1: read request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_addr` out 64: word-aligned read address.
- `mem_resp_valid` in 1: response valid. In order, one per accepted request, never earlier than the cycle after acceptance, no backpressure.
- `mem_resp_data` in 32: instruction word.
- `inst_valid` out 1: queue head valid.
- `inst_ready` in 1: core consumes head.
- `inst_data` out 32: head instruction.
- `inst_pc` out 64: head instruction address.
- `fetch_fault` out 1: misaligned redirect seen; fetch halted.

## Operation
- State machine: `RUN` and `FAULT`. Reset enters `RUN`.
  - `RUN` → `FAULT` on a redirect with `redirect_pc[1:0] != 0`.
  - `FAULT` → `RUN` on an aligned redirect.
  - A misaligned redirect in `FAULT` stays in `FAULT`.
- Registers: `fetch_pc` (next request address), `resp_pc` (address of the next kept response), `outstanding` (0..QDEPTH), `drop_cnt` (0..QDEPTH), `count` (0..QDEPTH), circular queue of `{pc[63:0], data[31:0]}`.
- Request issue: `mem_req_valid = (state==RUN) && (outstanding + count < QDEPTH)`. `mem_req_addr = fetch_pc`. On handshake, `fetch_pc += 4` and `outstanding++`. The credit rule guarantees every response has a queue slot.
- Response: `outstanding--`.
  - If `drop_cnt > 0`, discard the response and `drop_cnt--`.
  - Otherwise enqueue `{resp_pc, mem_resp_data}` and `resp_pc += 4`.
- Dequeue on `inst_valid && inst_ready`. `inst_valid = (count != 0)`. Simultaneous enqueue and dequeue keeps `count` unchanged, including when full.
- Redirect in cycle T:
  - Queue emptied. A dequeue handshake in T still completes.
  - `drop_cnt <= outstanding + req_hs(T) − resp_hs(T)`. The response in T is discarded.
  - `fetch_pc` and `resp_pc` load `redirect_pc` (aligned case). In `FAULT`, both are left unchanged.
  - `mem_req_valid` may deassert in T+1 without handshake. Memory must tolerate request withdrawal after redirect.
- A redirect while `drop_cnt > 0` accumulates correctly per the formula above, because `outstanding` already includes the stale requests.
- Address arithmetic wraps modulo 2^64.

## Timing
- Reset values:
  - `mem_req_valid` = 0 while `reset_n` is low.
  - `mem_req_addr` = `RESET_PC`.
  - `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0.
  - `fetch_fault` = 0.
  - All counters = 0.
- First `mem_req_valid` is asserted in the first cycle after `reset_n` is released.
- All outputs are driven from registers or queue state only. No combinational path from any input to any output.
- Latency: a response accepted at edge T is visible at `inst_valid` in cycle T+1.
- Redirect at edge T: first request to the new target is presented in cycle T+1.
- `fetch_fault` rises in the cycle after the misaligned redirect and clears in the cycle after an aligned redirect.
- Reset asserted mid-operation clears everything immediately. Memory is reset on the same `reset_n`, so no stale responses survive reset.

## Structure
- `tinker_pkg`: `TINKER_RESET_PC`, `INSTR_W = 32`, `ADDR_W = 64`, the `fetch_state_t` enum, and the `fetch_entry_t` struct `{pc, data}`.
- One sub-module: `tinker_fetch_queue`.
  - Parameterised synchronous FIFO of `fetch_entry_t` with `flush`, `push`, `pop`, `count`.
  - Pointers are `$clog2(QDEPTH)` bits and wrap naturally.
  - Top level holds the PC, counters and FSM.

## Test plan
- Reset, memory always ready with 1-cycle response, `inst_ready=1`: addresses 0x2000, 0x2004, 0x2008… in consecutive cycles; `inst_pc` matches each request; throughput of 1 per cycle.
- `inst_ready=0` for 10 cycles: exactly 4 requests issued, `count=4`, `mem_req_valid=0` thereafter; release → drains 0x2000..0x200C in order, then fetch resumes.
- 3 requests in flight (3-cycle memory latency), redirect to 0x3000: the 3 old responses are discarded, queue is empty, next `inst_pc` = 0x3000 with the correct data.
- Redirect in the same cycle as a response and a request handshake: `drop_cnt` = outstanding+1−1; no stale word reaches `inst_data`.
- Redirect to 0x3002: `fetch_fault=1`, no further requests; redirect to 0x4000 → fault clears, first fetch at 0x4000.
- Assert `reset_n=0` mid-stream with a full queue: outputs go to reset values immediately; restart fetches from 0x2000.

Source files
------------

// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker instruction fetch stage.
package tinker_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] TINKER_RESET_PC = 64'h2000;

    // RUN fetches normally; FAULT halts fetch after a misaligned redirect.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/tinker_fetch_queue.sv
// Circular instruction queue between the memory response port and decode.
// Flush empties it in one cycle; push and pop in the same cycle keep the
// count unchanged, including when the queue is full.
module tinker_fetch_queue
    import tinker_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head_entry,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [QDEPTH];

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (count_q == CNT_W'(QDEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full || do_pop);

    // Next pointer/count values; flush wins over push and pop.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_entry;
    end

    // Head is forced to zero when empty so stale storage never shows at the outputs.
    assign head_entry = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/tinker_fetch.sv
// Tinker instruction fetch stage: PC generation, credit-limited memory
// requests, in-order response buffering, redirect flush and stale-response
// discard, and misaligned-redirect fault handling.
module tinker_fetch
    import tinker_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = TINKER_RESET_PC,
    parameter int                QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_resp_valid,
    input  logic [INSTR_W-1:0]  mem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INSTR_W-1:0]  inst_data,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic                fetch_fault
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] QDEPTH_S = SUM_W'(QDEPTH);

    fetch_state_t      state_q, state_d;
    logic              started_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]  q_count;
    fetch_entry_t      q_head;
    fetch_entry_t      q_push_entry;
    logic              q_push;
    logic              q_pop;

    logic [SUM_W-1:0]  credit_used;
    logic              req_hs;
    logic              resp_hs;
    logic              redirect_aligned;

    // Requests are only issued while every possible response still has a queue slot.
    assign credit_used      = SUM_W'(outstanding_q) + SUM_W'(q_count);
    assign mem_req_valid    = started_q && (state_q == ST_RUN) && (credit_used < QDEPTH_S);
    assign mem_req_addr     = fetch_pc_q;
    assign req_hs           = mem_req_valid && mem_req_ready;
    assign resp_hs          = mem_resp_valid;
    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    // A response is kept only when nothing stale is pending and no redirect kills it.
    assign q_push       = resp_hs && (drop_cnt_q == '0) && !redirect_valid;
    assign q_push_entry = '{pc: resp_pc_q, data: mem_resp_data};
    assign q_pop        = inst_valid && inst_ready;

    // Next-state logic for the FSM, PCs and in-flight bookkeeping.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(resp_hs);
        drop_cnt_d    = drop_cnt_q;

        if (req_hs) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        if (q_push) resp_pc_d  = resp_pc_q + ADDR_W'(4);

        if (resp_hs && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_d = outstanding_d;
            if (redirect_aligned) begin
                state_d    = ST_RUN;
                fetch_pc_d = redirect_pc;
                resp_pc_d  = redirect_pc;
            end else begin
                state_d    = ST_FAULT;
                fetch_pc_d = fetch_pc_q;
                resp_pc_d  = resp_pc_q;
            end
        end
    end

    // Fetch state registers; started_q holds off requests until reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            started_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            started_q     <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    tinker_fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .head_entry (q_head),
        .count      (q_count)
    );

    assign inst_valid  = (q_count != '0);
    assign inst_data   = q_head.data;
    assign inst_pc     = q_head.pc;
    assign fetch_fault = (state_q == ST_FAULT);

endmodule
